// File: rtl/crop_window_scheduler.sv
// crop_window_scheduler
//   Arbitrates crop-window requests from the translation filter (req0) and the
//   scale filter (req1) onto one shared crop-range calculator. The calculator
//   result goes into a shadow register. The shadow is applied at the next
//   frame_start. Pixels of the incoming raster that fall inside the active
//   window are flagged.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req0/req1, pos*_x/y      level requests with target centres; ack0/ack1 pulse on capture
//   calc_start, calc_pos_x/y start pulse and held centre for the calculator
//   calc_*                   calculator window/offset results (valid CALC_LAT cycles after start)
//   frame_start, pix_valid   raster framing and pixel strobe
//   crop_valid, crop_last    registered in-window / last-in-window flags (1 cycle after pixel)
//   win_*, hls_pos_x/y       active window and target offset
//   win_valid, pending, busy status
module crop_window_scheduler #(
    parameter int unsigned IMG_WIDTH  = 1280,
    parameter int unsigned IMG_HEIGHT = 720,
    parameter int unsigned CALC_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] pos0_x,
    input  logic [15:0] pos0_y,
    input  logic        req1,
    input  logic [15:0] pos1_x,
    input  logic [15:0] pos1_y,
    output logic        ack0,
    output logic        ack1,
    output logic        calc_start,
    output logic [15:0] calc_pos_x,
    output logic [15:0] calc_pos_y,
    input  logic [11:0] calc_x_start,
    input  logic [11:0] calc_x_end,
    input  logic [11:0] calc_y_start,
    input  logic [11:0] calc_y_end,
    input  logic [15:0] calc_hls_x,
    input  logic [15:0] calc_hls_y,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        crop_valid,
    output logic        crop_last,
    output logic [11:0] win_x_start,
    output logic [11:0] win_x_end,
    output logic [11:0] win_y_start,
    output logic [11:0] win_y_end,
    output logic [15:0] hls_pos_x,
    output logic [15:0] hls_pos_y,
    output logic        win_valid,
    output logic        pending,
    output logic        busy
);

    localparam int unsigned CW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(CALC_LAT - 1);
    localparam logic [11:0]   X_MAX    = 12'(IMG_WIDTH);
    localparam logic [11:0]   Y_MAX    = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          grant_id;     // requester currently being served
    logic          last_grant;   // requester served most recently
    logic          sel1;         // arbitration result for this cycle
    logic          do_grant;
    logic          capture;

    logic [11:0] sh_x_start, sh_x_end, sh_y_start, sh_y_end;
    logic [15:0] sh_hls_x, sh_hls_y;

    logic [11:0] x, y;
    logic [11:0] cur_x, cur_y;
    logic        in_win;

    // Tie goes to the requester not served last.
    assign sel1 = req1 & ~(req0 & last_grant);

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        calc_start = 1'b0;
        capture    = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    do_grant  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                calc_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (wait_cnt == LAT_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                ack0      = ~grant_id;
                ack1      = grant_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            calc_pos_x <= '0;
            calc_pos_y <= '0;
        end else begin
            state <= state_nxt;
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            // calc_pos is only written at grant so it stays stable through CAPTURE.
            if (do_grant) begin
                grant_id   <= sel1;
                last_grant <= sel1;
                calc_pos_x <= sel1 ? pos1_x : pos0_x;
                calc_pos_y <= sel1 ? pos1_y : pos0_y;
            end
        end
    end

    // Shadow and active window. A frame_start coinciding with CAPTURE applies the
    // old shadow; the capture then keeps pending set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_start  <= '0;
            sh_x_end    <= '0;
            sh_y_start  <= '0;
            sh_y_end    <= '0;
            sh_hls_x    <= '0;
            sh_hls_y    <= '0;
            win_x_start <= '0;
            win_x_end   <= '0;
            win_y_start <= '0;
            win_y_end   <= '0;
            hls_pos_x   <= '0;
            hls_pos_y   <= '0;
            win_valid   <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (frame_start && pending) begin
                win_x_start <= sh_x_start;
                win_x_end   <= sh_x_end;
                win_y_start <= sh_y_start;
                win_y_end   <= sh_y_end;
                hls_pos_x   <= sh_hls_x;
                hls_pos_y   <= sh_hls_y;
                win_valid   <= 1'b1;
            end
            if (capture) begin
                sh_x_start <= calc_x_start;
                sh_x_end   <= calc_x_end;
                sh_y_start <= calc_y_start;
                sh_y_end   <= calc_y_end;
                sh_hls_x   <= calc_hls_x;
                sh_hls_y   <= calc_hls_y;
                pending    <= 1'b1;
            end else if (frame_start && pending) begin
                pending <= 1'b0;
            end
        end
    end

    // A frame_start with pix_valid evaluates that pixel as (1,0).
    always_comb begin
        cur_x  = frame_start ? 12'd1 : x;
        cur_y  = frame_start ? 12'd0 : y;
        in_win = win_valid &&
                 (cur_x >= win_x_start) && (cur_x <= win_x_end) &&
                 (cur_y >= win_y_start) && (cur_y <= win_y_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= 12'd1;
            y          <= '0;
            crop_valid <= 1'b0;
            crop_last  <= 1'b0;
        end else begin
            crop_valid <= pix_valid & in_win;
            crop_last  <= pix_valid & in_win & (cur_x == win_x_end) & (cur_y == win_y_end);
            if (pix_valid) begin
                if (cur_x == X_MAX) begin
                    if (cur_y != Y_MAX) begin
                        x <= 12'd1;
                        y <= cur_y + 12'd1;
                    end else begin
                        x <= cur_x;
                        y <= cur_y;
                    end
                end else begin
                    x <= cur_x + 12'd1;
                    y <= cur_y;
                end
            end else if (frame_start) begin
                x <= 12'd1;
                y <= '0;
            end
        end
    end

endmodule

// File: tb/tb_crop_window_scheduler.sv
// Scoreboard bench for crop_window_scheduler on a reduced 40x24 raster.
module tb_crop_window_scheduler;
    localparam int W   = 40;
    localparam int H   = 24;
    localparam int LAT = 3;

    typedef struct packed {
        logic [11:0] xs, xe, ys, ye;
        logic [15:0] hx, hy;
    } win_t;

    typedef struct {
        int          cyc;
        bit          id;
        logic [15:0] px, py;
    } req_exp_t;

    typedef struct {
        int   cyc;
        win_t w;
    } cap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] pos0_x = '0, pos0_y = '0, pos1_x = '0, pos1_y = '0;
    logic        ack0, ack1, calc_start;
    logic [15:0] calc_pos_x, calc_pos_y;
    logic [11:0] calc_x_start = '0, calc_x_end = '0, calc_y_start = '0, calc_y_end = '0;
    logic [15:0] calc_hls_x = '0, calc_hls_y = '0;
    logic        frame_start = 1'b0, pix_valid = 1'b0;
    logic        crop_valid, crop_last;
    logic [11:0] win_x_start, win_x_end, win_y_start, win_y_end;
    logic [15:0] hls_pos_x, hls_pos_y;
    logic        win_valid, pending, busy;

    crop_window_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CALC_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .pos0_x(pos0_x), .pos0_y(pos0_y),
        .req1(req1), .pos1_x(pos1_x), .pos1_y(pos1_y),
        .ack0(ack0), .ack1(ack1),
        .calc_start(calc_start), .calc_pos_x(calc_pos_x), .calc_pos_y(calc_pos_y),
        .calc_x_start(calc_x_start), .calc_x_end(calc_x_end),
        .calc_y_start(calc_y_start), .calc_y_end(calc_y_end),
        .calc_hls_x(calc_hls_x), .calc_hls_y(calc_hls_y),
        .frame_start(frame_start), .pix_valid(pix_valid),
        .crop_valid(crop_valid), .crop_last(crop_last),
        .win_x_start(win_x_start), .win_x_end(win_x_end),
        .win_y_start(win_y_start), .win_y_end(win_y_end),
        .hls_pos_x(hls_pos_x), .hls_pos_y(hls_pos_y),
        .win_valid(win_valid), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int cv_cnt = 0;
    int cl_cnt = 0;

    req_exp_t   exp_start_q[$];
    req_exp_t   exp_ack_q[$];
    cap_t       capq[$];
    logic [1:0] pixq[$];

    // Reference state: window pipeline and arbitration history.
    win_t m_shadow = '0, m_active = '0;
    bit   m_valid = 0, m_pending = 0;
    bit   lg_m = 1;

    logic pix_d = 1'b0, fs_d = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench calculator: 12x8 window centred on pos, clamped inside the raster.
    function automatic win_t calc_win(input int px, input int py);
        win_t w;
        int   xs, ys;
        xs = px - 5;
        if (xs < 1) xs = 1;
        if (xs + 11 > W) xs = W - 11;
        ys = py - 4;
        if (ys < 0) ys = 0;
        if (ys + 7 > H - 1) ys = H - 8;
        w.xs = 12'(xs);
        w.xe = 12'(xs + 11);
        w.ys = 12'(ys);
        w.ye = 12'(ys + 7);
        w.hx = 16'(px - xs);
        w.hy = 16'(py - ys);
        return w;
    endfunction

    // Reference model clock: frame application sees the old shadow, then capture.
    always @(posedge clk) begin
        pix_d <= pix_valid && !rst;
        fs_d  <= frame_start && !rst;
        if (rst) begin
            m_shadow  = '0;
            m_active  = '0;
            m_valid   = 0;
            m_pending = 0;
        end else begin
            if (frame_start && m_pending) begin
                m_active  = m_shadow;
                m_valid   = 1;
                m_pending = 0;
            end
            if (capq.size() > 0 && capq[0].cyc == cyc) begin
                m_shadow  = capq[0].w;
                m_pending = 1;
                void'(capq.pop_front());
            end
        end
        cyc = cyc + 1;
    end

    // Calculator environment: garbage until CALC_LAT cycles after calc_start.
    int   calc_cnt = -1;
    win_t calc_w;
    always @(negedge clk) begin
        if (rst) begin
            calc_cnt = -1;
        end else if (calc_start) begin
            calc_w   = calc_win(int'(calc_pos_x), int'(calc_pos_y));
            calc_cnt = 0;
            {calc_x_start, calc_x_end, calc_y_start, calc_y_end, calc_hls_x, calc_hls_y} =
                96'({$urandom, $urandom, $urandom});
        end else if (calc_cnt >= 0) begin
            calc_cnt++;
            if (calc_cnt == LAT) begin
                {calc_x_start, calc_x_end, calc_y_start, calc_y_end, calc_hls_x, calc_hls_y} = calc_w;
                calc_cnt = -1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    req_exp_t   mon_e;
    logic [1:0] mon_p;
    always @(negedge clk) begin
        if (!rst) begin
            if (calc_start) begin
                if (exp_start_q.size() == 0) chk("calc_start_unexpected", 1, 0);
                else begin
                    mon_e = exp_start_q.pop_front();
                    chk("calc_start_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("calc_start_pos", {calc_pos_x, calc_pos_y}, {mon_e.px, mon_e.py});
                end
            end
            if (ack0 || ack1) begin
                if (exp_ack_q.size() == 0) chk("ack_unexpected", {ack1, ack0}, 0);
                else begin
                    mon_e = exp_ack_q.pop_front();
                    chk("ack_id", {ack1, ack0}, mon_e.id ? 2'b10 : 2'b01);
                    chk("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
                    chk("ack_pos_stable", {calc_pos_x, calc_pos_y}, {mon_e.px, mon_e.py});
                end
            end
            if (pix_d) begin
                if (pixq.size() == 0) chk("crop_no_expectation", 1, 0);
                else begin
                    mon_p = pixq.pop_front();
                    chk("crop_flags", {crop_valid, crop_last}, mon_p);
                end
            end else if (crop_valid || crop_last) begin
                chk("crop_without_pixel", {crop_valid, crop_last}, 0);
            end
            if (fs_d) begin
                chk("frame_window",
                    {win_x_start, win_x_end, win_y_start, win_y_end, hls_pos_x, hls_pos_y}, m_active);
                chk("frame_win_valid", win_valid, m_valid);
                chk("frame_pending", pending, m_pending);
            end
            if (crop_valid) cv_cnt++;
            if (crop_last)  cl_cnt++;
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        exp_start_q.delete(); exp_ack_q.delete(); capq.delete(); pixq.delete();
        lg_m = 1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs",
            {ack0, ack1, calc_start, calc_pos_x, calc_pos_y, crop_valid, crop_last,
             win_x_start, win_x_end, win_y_start, win_y_end, hls_pos_x, hls_pos_y,
             win_valid, pending, busy}, '0);
    endtask

    // Raise requests in an idle cycle and queue the expected service order.
    task automatic start_req(input bit r0, input bit r1,
                             input logic [15:0] p0x, input logic [15:0] p0y,
                             input logic [15:0] p1x, input logic [15:0] p1y);
        bit          ids[$];
        int          n, base;
        req_exp_t    e;
        cap_t        c;
        logic [15:0] px, py;
        pos0_x = p0x; pos0_y = p0y; pos1_x = p1x; pos1_y = p1y;
        req0 = r0; req1 = r1;
        if (r0 && r1) ids = lg_m ? '{1'b0, 1'b1} : '{1'b1, 1'b0};
        else if (r0)  ids = '{1'b0};
        else          ids = '{1'b1};
        n = cyc;
        foreach (ids[k]) begin
            base  = n + k * (LAT + 3);
            px    = ids[k] ? p1x : p0x;
            py    = ids[k] ? p1y : p0y;
            e.id  = ids[k]; e.px = px; e.py = py;
            e.cyc = base + 1;
            exp_start_q.push_back(e);
            e.cyc = base + LAT + 2;
            exp_ack_q.push_back(e);
            c.cyc = base + LAT + 2;
            c.w   = calc_win(int'(px), int'(py));
            capq.push_back(c);
            lg_m  = ids[k];
        end
    endtask

    // Drop each request in its ack cycle; return in the following idle cycle.
    task automatic wait_acks(input bit r0, input bit r1);
        bit w0 = r0, w1 = r1;
        for (int i = 0; i < 40 && (w0 || w1); i++) begin
            @(negedge clk);
            if (ack0 && w0) begin req0 = 1'b0; w0 = 0; end
            if (ack1 && w1) begin req1 = 1'b0; w1 = 0; end
        end
        if (w0 || w1) begin
            chk("ack_timeout", {w1, w0}, 0);
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic check_status();
        chk("status_pending", pending, m_pending);
        chk("status_win_valid", win_valid, m_valid);
        chk("status_busy", busy, 0);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_pixels();
        int   cv0, cl0, area, x, y;
        bit   cv, cl;
        cv0  = cv_cnt;
        cl0  = cl_cnt;
        area = m_valid ? (int'(m_active.xe) - int'(m_active.xs) + 1) *
                         (int'(m_active.ye) - int'(m_active.ys) + 1) : 0;
        for (int i = 0; i < W * H; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            x  = i % W + 1;
            y  = i / W;
            cv = m_valid && x >= int'(m_active.xs) && x <= int'(m_active.xe) &&
                 y >= int'(m_active.ys) && y <= int'(m_active.ye);
            cl = cv && x == int'(m_active.xe) && y == int'(m_active.ye);
            pixq.push_back({cv, cl});
            pix_valid = 1'b1;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("frame_crop_count", 128'(cv_cnt - cv0), 128'(area));
        chk("frame_crop_last_count", 128'(cl_cnt - cl0), m_valid ? 128'd1 : 128'd0);
    endtask

    task automatic frame_with_pixels();
        pulse_fs();
        run_pixels();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] mask;
        do_reset(3);

        // Centred window.
        start_req(1, 0, 16'd20, 16'd12, 16'd0, 16'd0);
        wait_acks(1, 0);
        check_status();
        frame_with_pixels();

        // Ties: first to req0, then after a lone req0 the tie goes to req1.
        start_req(1, 1, 16'd10, 16'd6, 16'd30, 16'd18);
        wait_acks(1, 1);
        start_req(1, 0, 16'd15, 16'd9, 16'd0, 16'd0);
        wait_acks(1, 0);
        start_req(1, 1, 16'd25, 16'd10, 16'd8, 16'd20);
        wait_acks(1, 1);
        check_status();

        // Top-left and bottom-right clamps.
        start_req(0, 1, 16'd0, 16'd0, 16'd2, 16'd1);
        wait_acks(0, 1);
        frame_with_pixels();
        start_req(1, 0, 16'd38, 16'd22, 16'd0, 16'd0);
        wait_acks(1, 0);
        frame_with_pixels();

        // CAPTURE of B coincident with frame_start while A is pending.
        start_req(1, 0, 16'd12, 16'd5, 16'd0, 16'd0);
        wait_acks(1, 0);
        start_req(0, 1, 16'd0, 16'd0, 16'd27, 16'd15);
        repeat (4) @(negedge clk);
        fork
            wait_acks(0, 1);
            begin
                @(negedge clk);
                pulse_fs();
            end
        join
        check_status();
        frame_with_pixels();

        // Reset during WAIT abandons the request; re-present it.
        start_req(1, 0, 16'd33, 16'd3, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        do_reset(2);
        start_req(1, 0, 16'd33, 16'd3, 16'd0, 16'd0);
        wait_acks(1, 0);
        check_status();
        frame_with_pixels();

        // Randomized requests and frames.
        for (int it = 0; it < 6; it++) begin
            mask = 2'($urandom_range(1, 3));
            start_req(mask[0], mask[1],
                      16'($urandom_range(0, W + 5)), 16'($urandom_range(0, H + 3)),
                      16'($urandom_range(0, W + 5)), 16'($urandom_range(0, H + 3)));
            wait_acks(mask[0], mask[1]);
            if ($urandom_range(0, 2) == 0) pulse_fs();
            frame_with_pixels();
        end

        repeat (2) @(negedge clk);
        chk("leftover_expectations",
            128'(exp_start_q.size() + exp_ack_q.size() + capq.size() + pixq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
